audio_mixer: RTL and testbench

Sample-rate mixing stage between the SID core and the PWM output stage of the PET audio path. It does four things:
- captures the signed SID output on each 1 MHz sample strobe;
- adds the VIA CB2 beeper as a fixed-amplitude square term;
- applies a click-free ramped master volume with mute;
- saturates the result and delivers offset-binary 16-bit samples to the PWM modulator.

---
 rtl/audio_pkg.sv | 16 +
 rtl/gain_ramp.sv | 65 ++++++
 rtl/audio_mixer.sv | 104 ++++++++++
 tb/tb_audio_mixer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants, ramp state type and volume-to-gain mapping for the audio mixer.
package audio_pkg;
  localparam logic [15:0]        SILENCE           = 16'h8000;
  localparam int                 GAIN_W            = 5;
  localparam int                 GAIN_MAX          = 16;
  localparam logic signed [15:0] CB2_LEVEL_DEFAULT = 16'sd8192;

  typedef enum logic [1:0] {IDLE, UP, DOWN} ramp_state_t;

  // Full-scale volume maps to unity gain (16/16) rather than 15/16.
  function automatic logic [GAIN_W-1:0] vol_to_gain(input logic [3:0] vol, input logic mute);
    if (mute)              return '0;
    else if (vol == 4'd15) return GAIN_W'(GAIN_MAX);
    else                   return {1'b0, vol};
  endfunction
endpackage

// File: rtl/gain_ramp.sv
// Master volume register and click-free gain ramp: one gain step per 2**RAMP_SHIFT strobes.
// Gain only ever moves one step toward the live target, so it cannot overshoot.
module gain_ramp import audio_pkg::*; #(
  parameter int RAMP_SHIFT = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              sample_en_i,
  input  logic              mute_i,
  input  logic              vol_wr_i,
  input  logic [3:0]        vol_i,
  output logic [GAIN_W-1:0] gain_o,
  output logic              ramping_o
);
  localparam int              DIV_W    = (RAMP_SHIFT > 0) ? RAMP_SHIFT : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'((1 << RAMP_SHIFT) - 1);

  logic [3:0]        vol_q, vol_d;
  logic [GAIN_W-1:0] g_q, g_d, target;
  logic [DIV_W-1:0]  div_q, div_d;
  ramp_state_t       state_q, state_d;
  logic              ramping_q, ramping_d;

  always_comb begin
    target = vol_to_gain(vol_q, mute_i);
    vol_d  = vol_wr_i ? vol_i : vol_q;

    if (g_q < target)      state_d = UP;
    else if (g_q > target) state_d = DOWN;
    else                   state_d = IDLE;

    ramping_d = (state_d != IDLE);
    g_d       = g_q;
    div_d     = div_q;
    if (state_d == IDLE) begin
      div_d = '0;
    end else if (sample_en_i) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        g_d   = (state_d == UP) ? g_q + GAIN_W'(1) : g_q - GAIN_W'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      vol_q     <= 4'd15;
      g_q       <= '0;
      div_q     <= '0;
      state_q   <= IDLE;
      ramping_q <= 1'b0;
    end else begin
      vol_q     <= vol_d;
      g_q       <= g_d;
      div_q     <= div_d;
      state_q   <= state_d;
      ramping_q <= ramping_d;
    end
  end

  assign gain_o    = g_q;
  assign ramping_o = ramping_q && (state_q != IDLE);
endmodule

// File: rtl/audio_mixer.sv
// SID + CB2 beeper mixer with ramped master volume, saturating to offset-binary PWM samples.
// Strobe at edge T yields sample_valid_o at edge T+3; no backpressure, one sample per clk sustained.
module audio_mixer import audio_pkg::*; #(
  parameter logic signed [15:0] CB2_LEVEL  = CB2_LEVEL_DEFAULT,
  parameter int                 RAMP_SHIFT = 4
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        sample_en_i,
  input  logic [15:0] sid_i,
  input  logic        via_cb2_i,
  input  logic        diag_i,
  input  logic        mute_i,
  input  logic        vol_wr_i,
  input  logic [3:0]  vol_i,
  output logic [15:0] sample_o,
  output logic        sample_valid_o,
  output logic        ramping_o
);
  logic                     cb2_meta_q, cb2_meta_d, cb2_sync_q, cb2_sync_d;
  logic [GAIN_W-1:0]        gain;
  logic                     s1_vld_q, s1_vld_d, s1_cb2_q, s1_cb2_d;
  logic signed [15:0]       s1_sid_q, s1_sid_d;
  logic [GAIN_W-1:0]        s1_gain_q, s1_gain_d, s2_gain_q, s2_gain_d;
  logic                     s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d;
  logic signed [17:0]       s2_sum_q, s2_sum_d;
  logic signed [22:0]       prod;
  logic signed [18:0]       s3_scaled_q, s3_scaled_d;
  logic [15:0]              sat, sample_q, sample_d;
  logic                     valid_q, valid_d;

  gain_ramp #(.RAMP_SHIFT(RAMP_SHIFT)) u_ramp (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .sample_en_i(sample_en_i),
    .mute_i     (mute_i),
    .vol_wr_i   (vol_wr_i),
    .vol_i      (vol_i),
    .gain_o     (gain),
    .ramping_o  (ramping_o)
  );

  always_comb begin
    cb2_meta_d = via_cb2_i;
    cb2_sync_d = cb2_meta_q;

    s1_vld_d  = sample_en_i;
    s1_sid_d  = sample_en_i ? $signed(sid_i) : s1_sid_q;
    s1_cb2_d  = sample_en_i ? (cb2_sync_q & diag_i) : s1_cb2_q;
    s1_gain_d = sample_en_i ? gain : s1_gain_q;

    s2_vld_d  = s1_vld_q;
    s2_sum_d  = $signed({{2{s1_sid_q[15]}}, s1_sid_q})
              + (s1_cb2_q ? $signed({2'b00, CB2_LEVEL}) : 18'sd0);
    s2_gain_d = s1_gain_q;

    // Gain is unsigned 0..16; a zero sign bit keeps the multiply signed.
    prod        = 23'(s2_sum_q) * 23'($signed({1'b0, s2_gain_q}));
    s3_vld_d    = s2_vld_q;
    s3_scaled_d = 19'(prod >>> 4);

    if (s3_scaled_q > 19'sd32767)       sat = 16'h7FFF;
    else if (s3_scaled_q < -19'sd32768) sat = 16'h8000;
    else                                sat = s3_scaled_q[15:0];

    valid_d  = s3_vld_q;
    sample_d = s3_vld_q ? (sat ^ SILENCE) : sample_q;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cb2_meta_q  <= 1'b0;
      cb2_sync_q  <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_sid_q    <= '0;
      s1_cb2_q    <= 1'b0;
      s1_gain_q   <= '0;
      s2_vld_q    <= 1'b0;
      s2_sum_q    <= '0;
      s2_gain_q   <= '0;
      s3_vld_q    <= 1'b0;
      s3_scaled_q <= '0;
      valid_q     <= 1'b0;
      sample_q    <= SILENCE;
    end else begin
      cb2_meta_q  <= cb2_meta_d;
      cb2_sync_q  <= cb2_sync_d;
      s1_vld_q    <= s1_vld_d;
      s1_sid_q    <= s1_sid_d;
      s1_cb2_q    <= s1_cb2_d;
      s1_gain_q   <= s1_gain_d;
      s2_vld_q    <= s2_vld_d;
      s2_sum_q    <= s2_sum_d;
      s2_gain_q   <= s2_gain_d;
      s3_vld_q    <= s3_vld_d;
      s3_scaled_q <= s3_scaled_d;
      valid_q     <= valid_d;
      sample_q    <= sample_d;
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
endmodule

// File: tb/tb_audio_mixer.sv
// Drives two mixers (ramp shift 0 and 4) with shared stimulus against a sample-level reference model.
module tb_audio_mixer;
  logic        clk = 1'b0;
  logic        reset_n, sample_en, via_cb2, diag, mute, vol_wr;
  logic [15:0] sid;
  logic [3:0]  vol;
  logic [15:0] so0, so4;
  logic        sv0, sv4, rp0, rp4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  audio_mixer #(.RAMP_SHIFT(0)) dut0 (
    .clk_i(clk), .reset_n_i(reset_n), .sample_en_i(sample_en), .sid_i(sid),
    .via_cb2_i(via_cb2), .diag_i(diag), .mute_i(mute), .vol_wr_i(vol_wr), .vol_i(vol),
    .sample_o(so0), .sample_valid_o(sv0), .ramping_o(rp0));

  audio_mixer #(.RAMP_SHIFT(4)) dut4 (
    .clk_i(clk), .reset_n_i(reset_n), .sample_en_i(sample_en), .sid_i(sid),
    .via_cb2_i(via_cb2), .diag_i(diag), .mute_i(mute), .vol_wr_i(vol_wr), .vol_i(vol),
    .sample_o(so4), .sample_valid_o(sv4), .ramping_o(rp4));

  // Reference model state, index 0 -> shift 0, index 1 -> shift 4.
  int          m_g[2], m_div[2], m_vol[2];
  int          p_val[2][3];
  bit          p_vld[2][3];
  logic [15:0] m_out[2];
  bit          m_ovld[2], m_ramp[2];
  bit          h1, h2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_sample(input int s, input bit cb2, input int g);
    int sum, prod, q;
    sum  = s + (cb2 ? 8192 : 0);
    prod = sum * g;
    q    = prod / 16;
    if (prod < 0 && q * 16 != prod) q = q - 1;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q + 32768;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_g[d] = 0; m_div[d] = 0; m_vol[d] = 15;
      m_out[d] = 16'h8000; m_ovld[d] = 0; m_ramp[d] = 0;
      for (int k = 0; k < 3; k++) begin p_vld[d][k] = 0; p_val[d][k] = 0; end
    end
    h1 = 0; h2 = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_sample0"}, {16'h0, so0}, {16'h0, m_out[0]});
    chk({tag, "_valid0"},  {31'h0, sv0}, {31'h0, m_ovld[0]});
    chk({tag, "_ramp0"},   {31'h0, rp0}, {31'h0, m_ramp[0]});
    chk({tag, "_gain0"},   {27'h0, dut0.u_ramp.g_q}, 32'(m_g[0]));
    chk({tag, "_sample4"}, {16'h0, so4}, {16'h0, m_out[1]});
    chk({tag, "_valid4"},  {31'h0, sv4}, {31'h0, m_ovld[1]});
    chk({tag, "_ramp4"},   {31'h0, rp4}, {31'h0, m_ramp[1]});
    chk({tag, "_gain4"},   {27'h0, dut4.u_ramp.g_q}, 32'(m_g[1]));
  endtask

  task automatic tick();
    bit s_en, s_cb2, s_mute, s_wr, s_via;
    int s_sid, s_vol, tgt, sh;
    s_en = sample_en; s_sid = $signed(sid); s_cb2 = h2 & diag;
    s_mute = mute; s_wr = vol_wr; s_vol = vol; s_via = via_cb2;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      sh  = (d == 0) ? 0 : 4;
      tgt = s_mute ? 0 : ((m_vol[d] == 15) ? 16 : m_vol[d]);
      m_ovld[d] = p_vld[d][2];
      if (p_vld[d][2]) m_out[d] = 16'(p_val[d][2]);
      p_vld[d][2] = p_vld[d][1]; p_val[d][2] = p_val[d][1];
      p_vld[d][1] = p_vld[d][0]; p_val[d][1] = p_val[d][0];
      p_vld[d][0] = s_en;
      p_val[d][0] = ref_sample(s_sid, s_cb2, m_g[d]);
      m_ramp[d] = (m_g[d] != tgt);
      if (m_g[d] == tgt) m_div[d] = 0;
      else if (s_en) begin
        m_div[d]++;
        if (m_div[d] == (1 << sh)) begin
          m_div[d] = 0;
          m_g[d] = m_g[d] + ((m_g[d] < tgt) ? 1 : -1);
        end
      end
      if (s_wr) m_vol[d] = s_vol;
    end
    h2 = h1; h1 = s_via;
    #1;
    check_outputs("tick");
  endtask

  initial begin
    reset_n = 0; sample_en = 0; sid = '0; via_cb2 = 0; diag = 0;
    mute = 0; vol_wr = 0; vol = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    reset_n = 1;

    // Soft start at full volume with a constant SID level.
    sid = 16'd1000;
    repeat (20) begin
      sample_en = 1; tick();
      sample_en = 0; tick();
    end
    repeat (3) tick();
    chk("ramp_up_final", {16'h0, so0}, 32'h83E8);
    chk("ramp_up_done", {31'h0, rp0}, 32'h0);

    // Random mix of strobes, beeper, mute and volume writes.
    repeat (400) begin
      sample_en = 1'($urandom_range(0, 1));
      sid       = 16'($urandom);
      via_cb2   = 1'($urandom);
      diag      = 1'($urandom);
      mute      = ($urandom_range(0, 7) == 0);
      vol_wr    = ($urandom_range(0, 15) == 0);
      vol       = 4'($urandom);
      tick();
    end

    // Settle both instances at unity gain.
    mute = 0; vol_wr = 1; vol = 4'd15; sample_en = 0; via_cb2 = 0; diag = 0; tick();
    vol_wr = 0; sid = '0; sample_en = 1;
    repeat (300) tick();
    sample_en = 0;
    repeat (3) tick();

    // Saturation both ways.
    via_cb2 = 1; diag = 1;
    repeat (3) tick();
    sid = 16'h7FFF; sample_en = 1; tick();
    sample_en = 0; repeat (3) tick();
    chk("sat_hi0", {16'h0, so0}, 32'hFFFF);
    chk("sat_hi4", {16'h0, so4}, 32'hFFFF);
    via_cb2 = 0;
    repeat (3) tick();
    sid = 16'h8000; sample_en = 1; tick();
    sample_en = 0; repeat (3) tick();
    chk("sat_lo0", {16'h0, so0}, 32'h0000);
    chk("sat_lo4", {16'h0, so4}, 32'h0000);

    // Three back-to-back strobes.
    diag = 0;
    sample_en = 1; sid = 16'd100; tick();
    sid = 16'd200; tick();
    sid = 16'd300; tick();
    sample_en = 0;
    tick(); chk("b2b_0", {15'h0, sv0, so0}, 32'h18064);
    tick(); chk("b2b_1", {15'h0, sv0, so0}, 32'h180C8);
    tick(); chk("b2b_2", {15'h0, sv0, so0}, 32'h1812C);
    tick(); chk("b2b_end", {31'h0, sv0}, 32'h0);

    // Down-ramp to gain 8, then reverse toward full volume.
    vol_wr = 1; vol = 4'd0; tick();
    vol_wr = 0; sample_en = 1;
    repeat (128) begin sid = 16'($urandom); tick(); end
    chk("down_at8", {27'h0, dut4.u_ramp.g_q}, 32'd8);
    vol_wr = 1; vol = 4'd15; tick();
    vol_wr = 0;
    repeat (14) begin sid = 16'($urandom); tick(); end
    chk("rev_hold8", {27'h0, dut4.u_ramp.g_q}, 32'd8);
    tick();
    chk("rev_up9", {27'h0, dut4.u_ramp.g_q}, 32'd9);
    repeat (135) begin sid = 16'($urandom); tick(); end
    chk("rev_full", {27'h0, dut4.u_ramp.g_q}, 32'd16);

    // Mute drives a 256-strobe fade on the slow instance.
    mute = 1;
    repeat (128) begin sid = 16'($urandom); tick(); end
    chk("mute_mid_ramp", {31'h0, rp4}, 32'h1);
    repeat (128) begin sid = 16'($urandom); tick(); end
    chk("mute_gain0", {27'h0, dut4.u_ramp.g_q}, 32'd0);
    sid = 16'h7FFF; tick();
    sample_en = 0;
    repeat (3) tick();
    chk("mute_silent", {16'h0, so4}, 32'h8000);

    // Reset mid-ramp with samples in flight.
    mute = 0; sample_en = 1;
    repeat (6) begin sid = 16'($urandom); tick(); end
    sample_en = 0;
    #2 reset_n = 0;
    #1;
    model_reset();
    check_outputs("async_reset");
    @(negedge clk);
    reset_n = 1;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
